// File: rtl/out2in_arbiter_pkg.sv
// Shared types and widths for the two-source-to-one-sink burst arbiter.
package out2in_arbiter_pkg;

  typedef enum logic {SRC0 = 1'b0, SRC1 = 1'b1} src_t;

  localparam int RUN_W  = 4;
  localparam int STAT_W = 16;

endpackage

// File: rtl/out2in_arbiter_stage.sv
// One-entry output register: captures on load, drains when the sink takes the word.
module out2in_arbiter_stage #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [width-1:0] data_in,
  input  logic             enq_rdy,
  output logic             valid,
  output logic [width-1:0] data
);

  // Stage boundary p0 -> p1: data only moves on load, so it is stable while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= data_in;
    end else if (valid && enq_rdy) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/out2in_arbiter.sv
// Two-source burst arbiter feeding a one-entry output stage.
// Optional per-source grant counters: define OUT2IN_ARBITER_STATS_EN.
module out2in_arbiter
  import out2in_arbiter_pkg::*;
#(
  parameter int width = 32,
  parameter int BURST = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [width-1:0] in0_first,
  input  logic             in0_first__RDY,
  input  logic             in0_deq__RDY,
  output logic             in0_deq__ENA,
  input  logic [width-1:0] in1_first,
  input  logic             in1_first__RDY,
  input  logic             in1_deq__RDY,
  output logic             in1_deq__ENA,
  input  logic             out_enq__RDY,
  output logic             out_enq__ENA,
  output logic [width-1:0] out_enq_v,
  output logic             idle
`ifdef OUT2IN_ARBITER_STATS_EN
  ,
  output logic [STAT_W-1:0] stat0,
  output logic [STAT_W-1:0] stat1
`endif
);

  localparam logic [RUN_W-1:0] BURST_R = RUN_W'(BURST);

  logic             elig0, elig1;
  logic             load_p0;
  logic             gnt_vld_p0;
  src_t             gnt_p0;
  logic [width-1:0] data_p0;
  logic             vld_p1;
  logic [width-1:0] data_p1;
  src_t             last_q;
  logic [RUN_W-1:0] run_q;

  function automatic logic [RUN_W-1:0] sat_inc(input logic [RUN_W-1:0] r);
    if (r >= BURST_R) return BURST_R;
    return r + 1'b1;
  endfunction

  assign elig0   = in0_first__RDY && in0_deq__RDY;
  assign elig1   = in1_first__RDY && in1_deq__RDY;
  assign load_p0 = !vld_p1 || out_enq__RDY;

  // Stay on the last winner until its run reaches BURST, then hand over
  always_comb begin
    gnt_p0     = SRC0;
    gnt_vld_p0 = nRST && load_p0 && (elig0 || elig1);
    if (elig0 && elig1)
      gnt_p0 = (run_q < BURST_R) ? last_q : src_t'(~last_q);
    else if (elig1)
      gnt_p0 = SRC1;
  end

  assign in0_deq__ENA = gnt_vld_p0 && (gnt_p0 == SRC0);
  assign in1_deq__ENA = gnt_vld_p0 && (gnt_p0 == SRC1);
  assign data_p0      = (gnt_p0 == SRC1) ? in1_first : in0_first;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_q <= SRC0;
      run_q  <= '0;
    end else if (gnt_vld_p0) begin
      if (gnt_p0 == last_q) begin
        run_q <= sat_inc(run_q);
      end else begin
        last_q <= gnt_p0;
        run_q  <= RUN_W'(1);
      end
    end
  end

  out2in_arbiter_stage #(.width(width)) u_stage (
    .clk     (CLK),
    .rst_n   (nRST),
    .load    (gnt_vld_p0),
    .data_in (data_p0),
    .enq_rdy (out_enq__RDY),
    .valid   (vld_p1),
    .data    (data_p1)
  );

  assign out_enq__ENA = vld_p1 && out_enq__RDY;
  assign out_enq_v    = data_p1;
  assign idle         = !vld_p1;

`ifdef OUT2IN_ARBITER_STATS_EN
  // Counters wrap naturally at 16 bits
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stat0 <= '0;
      stat1 <= '0;
    end else begin
      if (in0_deq__ENA) stat0 <= stat0 + 1'b1;
      if (in1_deq__ENA) stat1 <= stat1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_out2in_arbiter.sv
// Scoreboard bench: BURST=4 instance (a) and BURST=1 instance (b) share stimulus.
module tb_out2in_arbiter;
  localparam int W = 32;

  logic         CLK = 1'b0;
  logic         nRST = 1'b0;
  logic [W-1:0] in0_first, in1_first;
  logic         in0_first_rdy, in0_deq_rdy, in1_first_rdy, in1_deq_rdy, out_rdy;
  logic         a_deq0, a_deq1, a_enq, a_idle;
  logic         b_deq0, b_deq1, b_enq, b_idle;
  logic [W-1:0] a_v, b_v;
`ifdef OUT2IN_ARBITER_STATS_EN
  logic [15:0]  a_stat0, a_stat1, b_stat0, b_stat1;
`endif

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  logic [W-1:0] last_push = '0;
  bit           chkb = 1'b0;
  bit           mon_en = 1'b1;

  always #5 CLK = ~CLK;

  out2in_arbiter #(.width(W), .BURST(4)) u_a (
    .CLK(CLK), .nRST(nRST),
    .in0_first(in0_first), .in0_first__RDY(in0_first_rdy), .in0_deq__RDY(in0_deq_rdy), .in0_deq__ENA(a_deq0),
    .in1_first(in1_first), .in1_first__RDY(in1_first_rdy), .in1_deq__RDY(in1_deq_rdy), .in1_deq__ENA(a_deq1),
    .out_enq__RDY(out_rdy), .out_enq__ENA(a_enq), .out_enq_v(a_v), .idle(a_idle)
`ifdef OUT2IN_ARBITER_STATS_EN
    , .stat0(a_stat0), .stat1(a_stat1)
`endif
  );

  out2in_arbiter #(.width(W), .BURST(1)) u_b (
    .CLK(CLK), .nRST(nRST),
    .in0_first(in0_first), .in0_first__RDY(in0_first_rdy), .in0_deq__RDY(in0_deq_rdy), .in0_deq__ENA(b_deq0),
    .in1_first(in1_first), .in1_first__RDY(in1_first_rdy), .in1_deq__RDY(in1_deq_rdy), .in1_deq__ENA(b_deq1),
    .out_enq__RDY(out_rdy), .out_enq__ENA(b_enq), .out_enq_v(b_v), .idle(b_idle)
`ifdef OUT2IN_ARBITER_STATS_EN
    , .stat0(b_stat0), .stat1(b_stat1)
`endif
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitors: pop the expected word whenever a DUT enqueues to its sink
  always @(negedge CLK) begin
    if (nRST && mon_en && a_enq) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_enq actual=%h required=none", a_v);
      end else begin
        chk("a_data", a_v, qa.pop_front());
      end
    end
  end

  always @(negedge CLK) begin
    if (nRST && b_enq) begin
      if (qb.size() != 0) begin
        chk("b_data", b_v, qb.pop_front());
      end else if (chkb) begin
        checks++; errors++;
        $display("FAIL b_unexpected_enq actual=%h required=none", b_v);
      end
    end
  end

  task automatic step(input logic [1:0] e0, input logic [1:0] e1, input logic rdy,
                      input logic x0, input logic x1, input logic xenq, input logic hold,
                      input logic cb, input logic xb0, input logic xb1);
    @(posedge CLK); #1;
    cyc++;
    in0_first = 32'hA000_0000 + W'(cyc);
    in1_first = 32'hB000_0000 + W'(cyc);
    {in0_first_rdy, in0_deq_rdy} = e0;
    {in1_first_rdy, in1_deq_rdy} = e1;
    out_rdy = rdy;
    #1;
    chk("a_deq0", W'(a_deq0), W'(x0));
    chk("a_deq1", W'(a_deq1), W'(x1));
    chk("a_enq", W'(a_enq), W'(xenq));
    if (hold) chk("a_hold", a_v, last_push);
    if (x0) begin qa.push_back(in0_first); last_push = in0_first; end
    else if (x1) begin qa.push_back(in1_first); last_push = in1_first; end
    if (cb) begin
      chk("b_deq0", W'(b_deq0), W'(xb0));
      chk("b_deq1", W'(b_deq1), W'(xb1));
      if (xb0) qb.push_back(in0_first);
      else if (xb1) qb.push_back(in1_first);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int ea[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
    int eb[9] = '{0, 1, 0, 1, 0, 1, 0, 1, 0};
    logic [1:0] pat[3] = '{2'b10, 2'b01, 2'b00};

    // Reset held with both sources eligible: nothing may be granted
    in0_first = 32'h1111_1111; in1_first = 32'h2222_2222;
    {in0_first_rdy, in0_deq_rdy, in1_first_rdy, in1_deq_rdy, out_rdy} = 5'b11111;
    #12;
    chk("rst_deq0", W'(a_deq0), '0);
    chk("rst_deq1", W'(a_deq1), '0);
    chk("rst_enq", W'(a_enq), '0);
    chk("rst_idle", W'(a_idle), W'(1));
    chk("rst_data", a_v, '0);
    {in0_first_rdy, in0_deq_rdy, in1_first_rdy, in1_deq_rdy, out_rdy} = 5'b00000;
    @(posedge CLK); #3 nRST = 1'b1;

    // Continuous contention: bursts of four on a, strict alternation on b
    chkb = 1'b1;
    for (int i = 0; i < 9; i++)
      step(2'b11, 2'b11, 1'b1, ea[i] == 0, ea[i] == 1, i > 0, 1'b0, 1'b1, eb[i] == 0, eb[i] == 1);
    chkb = 1'b0;
    step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("drain_idle", W'(a_idle), W'(1));

    // Only source 1 eligible; source 0 shows partial readiness
    for (int i = 0; i < 10; i++)
      step(pat[i % 3], 2'b11, i != 0, 1'b0, 1'b1, i > 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("run_sat", W'(u_a.run_q), W'(4));

    // Contention after a saturated run hands over, then sink stall and release
    step(2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(2'b11, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2'b00, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-stream drops the staged word
    @(posedge CLK); #3 nRST = 1'b0;
    #1;
    chk("mid_rst_deq0", W'(a_deq0), '0);
    chk("mid_rst_deq1", W'(a_deq1), '0);
    chk("mid_rst_enq", W'(a_enq), '0);
    chk("mid_rst_idle", W'(a_idle), W'(1));
    chk("mid_rst_data", a_v, '0);
    qa.delete();
    qb.delete();
    {in0_first_rdy, in0_deq_rdy, in1_first_rdy, in1_deq_rdy} = 4'b0000;
    @(posedge CLK); #3 nRST = 1'b1;

    step(2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2'b11, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("end_idle", W'(a_idle), W'(1));
    chk("qa_empty", W'(qa.size()), '0);

`ifdef OUT2IN_ARBITER_STATS_EN
    mon_en = 1'b0;
    @(posedge CLK); #3 nRST = 1'b0;
    #1;
    chk("stat0_rst", W'(a_stat0), '0);
    chk("stat1_rst", W'(a_stat1), '0);
    @(posedge CLK); #3 nRST = 1'b1;
    @(posedge CLK); #1;
    {in0_first_rdy, in0_deq_rdy, in1_first_rdy, in1_deq_rdy, out_rdy} = 5'b11001;
    repeat (70000) @(posedge CLK);
    #1;
    {in0_first_rdy, in0_deq_rdy} = 2'b00;
    chk("stat0_wrap", W'(a_stat0), W'(4464));
    chk("stat1_zero", W'(a_stat1), '0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/out2in_arbiter.md
OUT2IN_ARBITER -- requirements
Module: out2in_arbiter

Interface
REQ-001 SHALL have parameter width, default 32, data bits per transfer.
REQ-002 SHALL have parameter BURST, default 4, legal 1..15: maximum consecutive grants to one source while the other is eligible.
REQ-003 CLK  input  1  sole clock, rising edge.
REQ-004 nRST  input  1  asynchronous, active-low reset.
REQ-005 in0$first  input  width  head data of source 0.
REQ-006 in0$first__RDY  input  1  source 0 head valid.
REQ-007 in0$deq__RDY  input  1  source 0 can dequeue.
REQ-008 in0$deq__ENA  output  1  dequeue source 0 this cycle.
REQ-009 in1$first, in1$first__RDY, in1$deq__RDY, in1$deq__ENA  SHALL mirror REQ-005..008 for source 1.
REQ-010 out$enq__RDY  input  1  sink can accept.
REQ-011 out$enq__ENA  output  1  enqueue to sink this cycle.
REQ-012 out$enq$v  output  width  enqueued data.
REQ-013 idle  output  1  output stage empty.

Function
REQ-014 eligible_i SHALL be in_i$first__RDY && in_i$deq__RDY.
REQ-015 One-entry output stage (valid, data); out$enq__ENA = valid && out$enq__RDY; out$enq$v = stored data; idle = !valid.
REQ-016 Stage accepts (load) when !valid || out$enq__RDY, i.e. enq and load may coincide at full throughput.
REQ-017 When load and at least one eligible: exactly one in_i$deq__ENA asserted, combinationally, same cycle; in_i$first captured into stage at next edge; valid set.
REQ-018 Never more than one deq__ENA high; no deq__ENA when load is false.
REQ-019 Grant: only one eligible -> that one; both eligible -> last if run < BURST, else other.
REQ-020 State last (1 bit), run (4 bits): grant to last -> run = min(run+1, BURST); grant to other -> last = granted, run = 1; no grant -> unchanged.
REQ-021 BURST=1 SHALL yield strict alternation under continuous contention.
REQ-022 If load and nothing eligible: valid cleared if enq fired, else held.
REQ-023 Latency: deq to out$enq__ENA-eligible = 1 cycle; sustained 1 transfer/cycle when sink ready.
REQ-024 Stage data SHALL hold stable while valid && !out$enq__RDY.

Reset
REQ-025 nRST low SHALL asynchronously force valid=0, data=0, last=0, run=0; hence out$enq__ENA=0, deq__ENA=0 (all), idle=1.
REQ-026 Reset mid-transfer SHALL drop the staged word; first post-reset contended grant goes to source 0.

Configuration
REQ-027 Macro OUT2IN_ARBITER_STATS_EN defined: add outputs stat0, stat1 (16 bits each), grants per source, reset 0, wrap 0xFFFF->0x0000.
REQ-028 Macro undefined: stat ports and counters absent; all other behaviour identical.

Structure
REQ-029 Package out2in_arbiter_pkg SHALL hold src_t (SRC0, SRC1), RUN_W=4, STAT_W=16.
REQ-030 Sub-module out2in_arbiter_stage SHALL implement the one-entry output register (load, data in, enq ready, valid/data out).
REQ-031 Grant/run logic SHALL stay in out2in_arbiter.

Verification
REQ-032 After reset, both eligible, sink ready, BURST=4 -> grants 0,0,0,0,1,1,1,1,0 on consecutive cycles.
REQ-033 BURST=1, both eligible -> grants alternate 0,1,0,1; out$enq$v follows each deq one cycle later.
REQ-034 Only source 1 eligible for 10 cycles -> 10 grants to 1, run saturates at BURST, no deq to 0.
REQ-035 Sink stalls (out$enq__RDY=0) with stage full -> no deq__ENA, out$enq$v held; release -> enq and new load same cycle.
REQ-036 nRST pulsed low mid-stream -> outputs zero immediately (async), idle=1; next contended grant to source 0.
REQ-037 STATS_EN built, 70000 grants to source 0 -> stat0 = 70000 mod 65536 = 4464, stat1 = 0.
